// File: rtl/noc_local_if_pkg.sv
// Shared packet layout for the mesh local-port interface: field positions,
// widths and the packed body that travels through the FIFOs.
package noc_local_if_pkg;

  localparam int ID_W      = 4;
  localparam int SEQ_W     = 7;
  localparam int DATA_W    = 32;
  localparam int DROP_W    = 8;
  localparam int PKT_W     = 48;
  localparam int VALID_BIT = 47;
  localparam int BODY_W    = 47;

  localparam int DEST_LSB  = 43;
  localparam int SRC_LSB   = 39;
  localparam int SEQ_LSB   = 32;

  // Everything below the valid bit; valid is implied by FIFO occupancy.
  typedef struct packed {
    logic [ID_W-1:0]   dest;
    logic [ID_W-1:0]   src;
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
  } pkt_body_t;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with full/empty/count. A push while full is accepted only
// when a pop happens on the same edge.
module noc_fifo #(
  parameter int WIDTH = 47,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_local_if.sv
// Core-side network interface for one mesh switch: TX packetizer with a
// registered injection stage, RX ejection queue with drop/misroute tracking.
module noc_local_if
  import noc_local_if_pkg::*;
#(
  parameter int ID           = 0,
  parameter int PACKET_WIDTH = 48,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [3:0]              tx_dest,
  input  logic [31:0]             tx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [3:0]              rx_src,
  output logic [6:0]              rx_seq,
  output logic [31:0]             rx_data,
  output logic [PACKET_WIDTH-1:0] pkt_to_sw,
  input  logic                    busy_in,
  input  logic [PACKET_WIDTH-1:0] pkt_from_sw,
  output logic                    busy_out,
  output logic [7:0]              drop_cnt,
  output logic                    misroute
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  // Handshakes: a core transfer happens at a rising edge where valid && ready;
  // valid never waits on ready, and the offered item holds until it transfers.

  logic [PACKET_WIDTH-1:0] stage_q;
  logic [SEQ_W-1:0]        seq_q;
  logic [DROP_W-1:0]       drop_q;
  logic                    misroute_q;

  pkt_body_t        tx_body;
  logic [BODY_W-1:0] tx_head;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic [TCW-1:0]   unused_tx_count;
  logic             stage_load;

  logic [BODY_W-1:0] rx_head;
  logic             rx_in_valid;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic [RCW-1:0]   rx_count;
  logic             rx_drop;
  logic [ID_W-1:0]  unused_rx_dest;

  // ---------------- TX path ----------------
  assign tx_ready = nreset && !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_body  = '{dest: tx_dest, src: ID_W'(ID), seq: seq_q, data: tx_data};

  // The stage refills whenever it is empty or its packet leaves this edge.
  assign stage_load = !stage_q[VALID_BIT] || !busy_in;
  assign tx_pop     = stage_load && !tx_empty;

  noc_fifo #(.WIDTH(BODY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (tx_push),
    .wdata  (tx_body),
    .pop    (tx_pop),
    .rdata  (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (unused_tx_count)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      stage_q <= '0;
      seq_q   <= '0;
    end else begin
      if (stage_load) stage_q <= tx_empty ? '0 : {1'b1, tx_head};
      if (tx_push)    seq_q   <= seq_q + SEQ_W'(1);
    end
  end

  assign pkt_to_sw = stage_q;

  // ---------------- RX path ----------------
  assign rx_in_valid = nreset && pkt_from_sw[VALID_BIT];
  assign rx_pop      = rx_valid && rx_ready;
  assign rx_push     = rx_in_valid && (!rx_full || rx_pop);
  assign rx_drop     = rx_in_valid && !rx_push;

  noc_fifo #(.WIDTH(BODY_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (rx_push),
    .wdata  (pkt_from_sw[BODY_W-1:0]),
    .pop    (rx_pop),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      drop_q     <= '0;
      misroute_q <= 1'b0;
    end else begin
      if (rx_drop && drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + DROP_W'(1);
      if (rx_in_valid && pkt_from_sw[DEST_LSB +: ID_W] != ID_W'(ID)) misroute_q <= 1'b1;
    end
  end

  assign rx_valid       = nreset && !rx_empty;
  assign rx_src         = rx_head[SRC_LSB +: ID_W];
  assign rx_seq         = rx_head[SEQ_LSB +: SEQ_W];
  assign rx_data        = rx_head[DATA_W-1:0];
  assign unused_rx_dest = rx_head[DEST_LSB +: ID_W];

  // Leaves room for the packet the switch may already have launched.
  assign busy_out = nreset && (rx_count >= RCW'(RX_DEPTH - 1));
  assign drop_cnt = drop_q;
  assign misroute = misroute_q;

endmodule
